// File: rtl/icap_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icap_feeder_pkg
//  Description : Shared widths, FSM state encoding and the per-byte bit
//                reversal helper for the ICAP feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package icap_feeder_pkg;

    localparam int c_line_w         = 256;
    localparam int c_icap_w         = 32;
    localparam int c_words_per_line = c_line_w / c_icap_w;
    localparam int c_rem_w          = 20;
    localparam int c_wcnt_w         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_t;

    // ICAP expects the bits inside each byte in reverse order.
    function automatic logic [c_icap_w-1:0] byte_bitrev(input logic [c_icap_w-1:0] word);
        logic [c_icap_w-1:0] rev;
        for (int b = 0; b < c_icap_w / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                rev[8*b+i] = word[8*b+7-i];
            end
        end
        return rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icap_feeder_line_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : line_fifo
//  Description : Synchronous line FIFO with occupancy count, registered
//                almost-full flag, sticky overflow flag and a flush input.
//  Ports       : i_clk/i_rst_n   clock, async active-low reset
//                i_push/i_data   write strobe and line
//                i_pop           read strobe (o_data is the head line)
//                i_flush         empty the FIFO; wins over a same-cycle push
//                o_count         current occupancy
//                o_empty         occupancy is zero
//                o_almost_full   DEPTH-count <= AF_MARGIN, registered
//                o_overflow      sticky: push refused while full
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fifo #(
    parameter int WIDTH     = 256,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_almost_full;
    logic             r_overflow;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    // A full FIFO still accepts a line when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            // Flag is derived from the next count so it tracks r_count exactly.
            r_almost_full <= (int'(w_count_nxt) + AF_MARGIN >= DEPTH);
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
            if (i_push && w_full && !w_do_pop && !i_flush) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_data        = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_empty       = (r_count == '0);
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: rtl/icap_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : icap_feeder
//  Description : Buffers 256-bit DDR read lines and serialises them into
//                32-bit ICAP write words until a programmed word count has
//                been written.
//  Ports       : i_clk/i_rst_n        clock, async active-low reset
//                i_ddr_data(_valid)   incoming DDR lines, one per strobe
//                o_config_buff_full   almost-full back-pressure to DDR reads
//                i_start/i_total_words  start pulse and word count
//                o_icap_data/csib/rdwrb ICAP write interface
//                o_icap_en            ~o_icap_csib, for statistics
//                o_done               one-cycle end-of-configuration pulse
//                o_overflow           sticky line-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
module icap_feeder
    import icap_feeder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2,
    parameter int BIT_SWAP  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [c_line_w-1:0] i_ddr_data,
    input  logic                i_ddr_data_valid,
    output logic                o_config_buff_full,
    input  logic                i_start,
    input  logic [c_rem_w-1:0]  i_total_words,
    output logic [c_icap_w-1:0] o_icap_data,
    output logic                o_icap_csib,
    output logic                o_icap_rdwrb,
    output logic                o_icap_en,
    output logic                o_done,
    output logic                o_overflow
);

    feeder_state_t          r_state;
    logic [c_line_w-1:0]    r_shift;
    logic [c_wcnt_w-1:0]    r_word_cnt;
    logic [c_rem_w-1:0]     r_remaining;
    logic [c_icap_w-1:0]    r_icap_data;
    logic                   r_csib;
    logic                   r_done;

    logic [c_line_w-1:0]    w_fifo_data;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                   w_fifo_empty;
    logic                   w_emit;
    logic                   w_pop;
    logic                   w_flush;
    logic [c_icap_w-1:0]    w_word_out;

    line_fifo #(
        .WIDTH     (c_line_w),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_push        (i_ddr_data_valid),
        .i_data        (i_ddr_data),
        .i_pop         (w_pop),
        .i_flush       (w_flush),
        .o_data        (w_fifo_data),
        .o_count       (w_fifo_count),
        .o_empty       (w_fifo_empty),
        .o_almost_full (o_config_buff_full),
        .o_overflow    (o_overflow)
    );

    assign w_emit  = (r_state == ST_RUN) && (r_word_cnt != '0);
    // Reload when the shift register is empty, or when its last word leaves
    // this cycle, so consecutive lines produce gap-free output.
    assign w_pop   = (r_state == ST_RUN) && (r_word_cnt <= c_wcnt_w'(1)) && !w_fifo_empty;
    assign w_flush = (r_state == ST_DONE);

    assign w_word_out = (BIT_SWAP != 0) ? byte_bitrev(r_shift[c_icap_w-1:0])
                                        : r_shift[c_icap_w-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_word_cnt  <= '0;
            r_remaining <= '0;
            r_icap_data <= '0;
            r_csib      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_csib <= 1'b1;
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_remaining <= i_total_words;
                        r_word_cnt  <= '0;
                        r_state     <= (i_total_words == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_done <= 1'b0;
                    if (w_emit) begin
                        r_icap_data <= w_word_out;
                        r_csib      <= 1'b0;
                        r_remaining <= r_remaining - c_rem_w'(1);
                        r_shift     <= r_shift >> c_icap_w;
                        r_word_cnt  <= r_word_cnt - c_wcnt_w'(1);
                        if (r_remaining == c_rem_w'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        // Starved: hold the last word, deselect ICAP.
                        r_csib <= 1'b1;
                    end
                    if (w_pop) begin
                        r_shift    <= w_fifo_data;
                        r_word_cnt <= c_wcnt_w'(c_words_per_line);
                    end
                end
                ST_DONE: begin
                    r_csib     <= 1'b1;
                    r_done     <= 1'b1;
                    r_word_cnt <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_icap_data  = r_icap_data;
    assign o_icap_csib  = r_csib;
    assign o_icap_rdwrb = 1'b0;
    assign o_icap_en    = ~r_csib;
    assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_icap_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icap_feeder
//  Description : Scoreboard bench for icap_feeder. The driver queues the
//                expected ICAP words as lines are pushed; a monitor pops and
//                compares them whenever the DUT enables ICAP.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icap_feeder;

    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 2;
    localparam int BIT_SWAP  = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] ddr_data = '0;
    logic         ddr_valid = 1'b0;
    logic         buff_full;
    logic         start = 1'b0;
    logic [19:0]  total_words = '0;
    logic [31:0]  icap_data;
    logic         icap_csib;
    logic         icap_rdwrb;
    logic         icap_en;
    logic         done;
    logic         overflow;

    icap_feeder #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .BIT_SWAP(BIT_SWAP)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_ddr_data         (ddr_data),
        .i_ddr_data_valid   (ddr_valid),
        .o_config_buff_full (buff_full),
        .i_start            (start),
        .i_total_words      (total_words),
        .o_icap_data        (icap_data),
        .o_icap_csib        (icap_csib),
        .o_icap_rdwrb       (icap_rdwrb),
        .o_icap_en          (icap_en),
        .o_done             (done),
        .o_overflow         (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_q[$];
    int exp_total = 0;
    int start_cyc = 0;
    int first_en_cyc = 0;
    int last_en_cyc = 0;
    int en_cnt = 0;
    bit run_done = 1'b0;
    int last_push_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: word k of a line, optionally bit-reversed within each byte.
    function automatic logic [31:0] model_word(input logic [255:0] line, input int k);
        logic [31:0] w;
        logic [31:0] r;
        w = line[32*k +: 32];
        if (BIT_SWAP == 0) return w;
        for (int i = 0; i < 32; i++) r[i] = w[(i / 8) * 8 + (7 - i % 8)];
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] prev_data = '0;
    bit          prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_data = '0;
            prev_done = 1'b0;
        end else begin
            check("rdwrb", 64'(icap_rdwrb), 64'd0);
            check("en_vs_csib", 64'(icap_en), 64'(!icap_csib));
            if (icap_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", icap_data);
                end else begin
                    check("word", 64'(icap_data), 64'(exp_q.pop_front()));
                end
                if (en_cnt == 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                en_cnt++;
            end else begin
                check("data_hold", 64'(icap_data), 64'(prev_data));
            end
            if (done) begin
                check("done_width", 64'(prev_done), 64'd0);
                check("word_count", 64'(en_cnt), 64'(exp_total));
                check("done_time", 64'(cyc),
                      64'((exp_total == 0) ? start_cyc + 1 : last_en_cyc + 1));
                exp_q.delete();
                run_done = 1'b1;
            end
            prev_data = icap_data;
            prev_done = done;
        end
    end

    // ---------------- driver helpers (enter and leave at a negedge) -------
    task automatic drive_line(input logic [255:0] line, input bit track);
        ddr_data  = line;
        ddr_valid = 1'b1;
        if (track) for (int k = 0; k < 8; k++) exp_q.push_back(model_word(line, k));
        @(negedge clk);
        ddr_valid = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic do_start(input int total);
        exp_total   = total;
        en_cnt      = 0;
        run_done    = 1'b0;
        total_words = 20'(total);
        start       = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500 && !run_done; i++) @(negedge clk);
        if (!run_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(negedge clk);
        check("fifo_flushed", 64'(dut.w_fifo_count), 64'd0);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [255:0] line;
        int           p1;
        int           nlines;
        int           pre;
        int           total;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_csib", 64'(icap_csib), 64'd1);
        check("rst_en", 64'(icap_en), 64'd0);
        check("rst_data", 64'(icap_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_full", 64'(buff_full), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- 1: one line, word k = k, pushed while running ----
        for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'(k);
        do_start(8);
        drive_line(line, 1'b1);
        p1 = last_push_cyc;
        wait_done();
        check("t1_latency", 64'(first_en_cyc), 64'(p1 + 2));
        check("t1_gapfree", 64'(last_en_cyc - first_en_cyc), 64'd7);

        // ---- 2: three preloaded lines, total 20 ----
        for (int i = 0; i < 3; i++) drive_line(rand_line(), 1'b1);
        check("t2_full_preload", 64'(buff_full), 64'd1);
        do_start(20);
        wait_done();
        check("t2_en_cycles", 64'(last_en_cyc - first_en_cyc + 1), 64'd20);

        // ---- 5: total 0 ----
        do_start(0);
        wait_done();

        // ---- 4: starvation between two lines ----
        do_start(16);
        drive_line(rand_line(), 1'b1);
        repeat (12) @(negedge clk);
        drive_line(rand_line(), 1'b1);
        p1 = last_push_cyc;
        wait_done();
        check("t4_resume", 64'(last_en_cyc), 64'(p1 + 9));

        // ---- 3: fill while idle, then overflow ----
        for (int i = 1; i <= 5; i++) begin
            int occ;
            drive_line(rand_line(), i <= DEPTH);
            occ = (i < DEPTH) ? i : DEPTH;
            check("t3_count", 64'(dut.w_fifo_count), 64'(occ));
            check("t3_full", 64'(buff_full), 64'(DEPTH - occ <= AF_MARGIN));
            check("t3_overflow", 64'(overflow), 64'(i > DEPTH));
        end
        do_start(32);
        wait_done();
        check("t3_overflow_sticky", 64'(overflow), 64'd1);

        // ---- 6: reset mid-line ----
        do_start(8);
        drive_line(rand_line(), 1'b1);
        for (int i = 0; i < 50 && en_cnt < 4; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_reached_word3", 64'(en_cnt), 64'd4);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_csib", 64'(icap_csib), 64'd1);
        check("t6_rst_en", 64'(icap_en), 64'd0);
        check("t6_rst_data", 64'(icap_data), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        en_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_fifo_empty", 64'(dut.w_fifo_count), 64'd0);
        check("t6_full", 64'(buff_full), 64'd0);
        do_start(8);
        drive_line(rand_line(), 1'b1);
        wait_done();

        // ---- randomized runs ----
        for (int r = 0; r < 25; r++) begin
            total  = $urandom_range(1, 40);
            nlines = (total + 7) / 8;
            pre    = $urandom_range(0, (nlines < 2) ? nlines : 2);
            for (int i = 0; i < pre; i++) drive_line(rand_line(), 1'b1);
            do_start(total);
            for (int i = pre; i < nlines; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                for (int w = 0; w < 200 && buff_full; w++) @(negedge clk);
                drive_line(rand_line(), 1'b1);
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
